keypad_digit_buffer: RTL and testbench
======================================

# keypad_digit_buffer

Multi-digit BCD entry buffer for the microwave keypad path. Each key press is captured as one decimal digit, clamped to a legal BCD range, and shifted into a DIGITS-wide entry register. A commit sends the completed entry to the cook timer over a valid/ready handshake. The block sits between the keypad decoder and the countdown timer load port, and replaces per-digit combinational clamping with a buffered, parametrised entry stage.

## Interface
- DIGITS, 4: number of BCD digits held; legal range 2..8.
- MAX_DIGIT, 9: upper clamp applied to every captured digit; legal range 1..9.
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- key_code  in  4  raw key value from the keypad decoder.
- key_valid  in  1  level-high while a key is held; synchronous to clk.
- clear  in  1  single-cycle request to discard the current entry.
- commit  in  1  single-cycle request to offer the entry to the timer.
- load_ready  in  1  timer accepts the entry.
- digits  out  4*DIGITS  BCD entry; digit 0 (least significant) is in bits [3:0].
- count  out  $clog2(DIGITS+1)  number of digits entered.
- load_valid  out  1  entry offered to the timer.
- full  out  1  count == DIGITS.
- overflow  out  1  sticky; set when a key press is dropped because the buffer is full.

## Operation
- Key press: a rising edge of key_valid, meaning the registered previous value is 0 and the current value is 1. Holding the key produces exactly one capture.
- Clamp: the captured value is min(key_code, MAX_DIGIT), compared as unsigned 4-bit.
- Capture: digits <= {digits[4*DIGITS-5:0], clamped}. count increments, saturating at DIGITS. A leading 0 still increments count.
- States:
  - EMPTY (count=0): a press captures and moves to ENTRY; a commit is ignored.
  - ENTRY: a press captures. When count reaches DIGITS, move to FULL. A commit moves to OFFER.
  - FULL: a press is dropped and sets overflow. A commit moves to OFFER.
  - OFFER: load_valid=1; digits and count are frozen; key presses are dropped without setting overflow; clear and commit are ignored. When load_valid & load_ready, move to EMPTY, zero digits and count, and clear overflow.
- Clear in EMPTY, ENTRY or FULL: move to EMPTY, zero digits and count, clear overflow.
- Simultaneous events in the same cycle, highest priority first: clear, then commit, then key press. A key press coinciding with clear or commit is discarded.
- full is combinational from count. overflow is registered.

## Timing
- Reset values: digits=0, count=0, load_valid=0, full=0, overflow=0, state EMPTY, and the key_valid history register at 0.
- Capture latency is 1 cycle. digits and count update on the clock edge where the key_valid rising edge is first sampled.
- load_valid rises on the edge after commit is sampled. It stays high until the handshake completes, with no timeout.
- The handshake is accepted on the edge where load_valid=1 and load_ready=1 are both sampled. load_valid is 0 from that edge onward, and digits=0 and count=0 after the same edge.
- load_ready while load_valid=0 has no effect.
- Asserting rst_n low at any time, including during OFFER, forces all reset values immediately. No transfer completes.
- After rst_n deasserts, a key_valid that is already high produces one capture, because the history register resets to 0.

## Configuration
- KEYPAD_MMSS_EN:
  - Defined: the entry is treated as MM:SS. Digit 1, the tens of seconds, is clamped to min(MAX_DIGIT, 5) at the moment it lands in position 1. That happens when the second digit shifts it there, so the clamp is applied on every shift into position 1. All other digits clamp to MAX_DIGIT.
  - Not defined: every digit clamps to MAX_DIGIT only.

## Test plan
- Reset, then DIGITS=4, key_code=3 with key_valid held high for 5 cycles -> exactly one capture: digits=0x0003, count=1.
- Press keys 1, 2, 12, 7 -> digits=0x1297, count=4, full=1. A fifth press of 4 -> digits unchanged, overflow=1.
- Entry 0x0012, commit, load_ready held low for 10 cycles -> load_valid stays 1 and digits stays 0x0012. Raise load_ready -> after that edge load_valid=0, digits=0, count=0.
- In ENTRY, assert clear and a key press in the same cycle -> digits=0 and count=0 afterwards, and the key is not captured. Assert commit in EMPTY -> load_valid stays 0.
- Enter 0x0012, commit, then drop rst_n while load_valid=1 -> all outputs are 0 immediately. After release, no load_valid appears.
- With KEYPAD_MMSS_EN defined, press 9 then 0 -> digits=0x0050. Without the macro -> digits=0x0090.

Source files
------------

// File: rtl/keypad_digit_buffer_if.sv
// keypad_digit_buffer_if: keypad-to-timer entry bus; master drives keys/handshake, slave returns the BCD entry and status
interface keypad_digit_buffer_if #(parameter int DIGITS = 4);
  logic [3:0] key_code;
  logic key_valid;
  logic clear;
  logic commit;
  logic load_ready;
  logic [4*DIGITS-1:0] digits;
  logic [$clog2(DIGITS+1)-1:0] count;
  logic load_valid;
  logic full;
  logic overflow;
  modport master (
    output key_code, key_valid, clear, commit, load_ready,
    input  digits, count, load_valid, full, overflow
  );
  modport slave (
    input  key_code, key_valid, clear, commit, load_ready,
    output digits, count, load_valid, full, overflow
  );
endinterface

// File: rtl/keypad_digit_buffer.sv
// keypad_digit_buffer: clamps key presses to BCD, shifts them into a DIGITS-wide entry, offers it via valid/ready (clk, rst_n async low, bus slave; KEYPAD_MMSS_EN clamps tens-of-seconds to 5)
module keypad_digit_buffer #(
  parameter int DIGITS = 4,
  parameter int MAX_DIGIT = 9
) (
  input logic clk,
  input logic rst_n,
  keypad_digit_buffer_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int DW = 4 * DIGITS;
  localparam logic [3:0] DMAX = 4'(MAX_DIGIT);
`ifdef KEYPAD_MMSS_EN
  localparam logic [3:0] TMAX = 4'(MAX_DIGIT < 5 ? MAX_DIGIT : 5);
`endif
  typedef enum logic [1:0] {EMPTY, ENTRY, FULL, OFFER} state_t;
  state_t state, state_n;
  logic [DW-1:0] digits, digits_n, shifted;
  logic [CW-1:0] count, count_n, count_inc;
  logic ovf, ovf_n, key_q, press;
  logic [3:0] clamped;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      digits <= '0;
      count <= '0;
      ovf <= 1'b0;
      key_q <= 1'b0;
    end else begin
      state <= state_n;
      digits <= digits_n;
      count <= count_n;
      ovf <= ovf_n;
      key_q <= bus.key_valid;
    end
  always_comb begin
    press = bus.key_valid & ~key_q;
    clamped = bus.key_code > DMAX ? DMAX : bus.key_code;
    shifted = {digits[DW-5:0], clamped};
`ifdef KEYPAD_MMSS_EN
    // the digit moving into position 1 becomes tens of seconds
    shifted[7:4] = digits[3:0] > TMAX ? TMAX : digits[3:0];
`endif
    count_inc = count + 1'b1;
    state_n = state;
    digits_n = digits;
    count_n = count;
    ovf_n = ovf;
    if (state == OFFER) begin
      if (bus.load_ready) begin
        state_n = EMPTY;
        digits_n = '0;
        count_n = '0;
        ovf_n = 1'b0;
      end
    end else if (bus.clear) begin
      state_n = EMPTY;
      digits_n = '0;
      count_n = '0;
      ovf_n = 1'b0;
    end else if (bus.commit) begin
      state_n = state == EMPTY ? EMPTY : OFFER;
    end else if (press) begin
      if (state == FULL) begin
        ovf_n = 1'b1;
      end else begin
        digits_n = shifted;
        count_n = count_inc;
        state_n = count_inc == CW'(DIGITS) ? FULL : ENTRY;
      end
    end
  end
  assign bus.digits = digits;
  assign bus.count = count;
  assign bus.load_valid = state == OFFER;
  assign bus.full = count == CW'(DIGITS);
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_keypad_digit_buffer.sv
// tb_keypad_digit_buffer: table-driven and directed checks of keypad_digit_buffer (DIGITS=4, MAX_DIGIT=9)
module tb_keypad_digit_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  keypad_digit_buffer_if #(.DIGITS(4)) bus ();
  keypad_digit_buffer #(.DIGITS(4), .MAX_DIGIT(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`ifdef KEYPAD_MMSS_EN
  localparam logic [15:0] E4 = 16'h1257;
  localparam logic [15:0] E90 = 16'h0050;
`else
  localparam logic [15:0] E4 = 16'h1297;
  localparam logic [15:0] E90 = 16'h0090;
`endif
  typedef struct {
    logic [3:0] kc;
    logic kv, clr, cm, lr;
    logic [15:0] d;
    logic [2:0] c;
    logic lv, o;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(logic [3:0] kc, logic kv, logic clr, logic cm, logic lr,
                              logic [15:0] d, logic [2:0] c, logic lv, logic o);
    vec_t r;
    r.kc = kc; r.kv = kv; r.clr = clr; r.cm = cm; r.lr = lr;
    r.d = d; r.c = c; r.lv = lv; r.o = o;
    return r;
  endfunction
  task automatic drive(logic [3:0] kc, logic kv, logic clr, logic cm, logic lr);
    @(negedge clk);
    bus.key_code = kc;
    bus.key_valid = kv;
    bus.clear = clr;
    bus.commit = cm;
    bus.load_ready = lr;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [15:0] d, logic [2:0] c, logic lv, logic o);
    logic [21:0] act, req;
    act = {bus.digits, bus.count, bus.load_valid, bus.full, bus.overflow};
    req = {d, c, lv, c == 3'd4, o};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got digits=%h count=%0d lv=%b full=%b ovf=%b, want digits=%h count=%0d lv=%b full=%b ovf=%b",
               name, bus.digits, bus.count, bus.load_valid, bus.full, bus.overflow,
               d, c, lv, c == 3'd4, o);
    end
  endtask
  task automatic press(logic [3:0] k);
    drive(k, 1, 0, 0, 0);
    drive(k, 0, 0, 0, 0);
  endtask
  initial begin
    bus.key_code = 0; bus.key_valid = 0; bus.clear = 0; bus.commit = 0; bus.load_ready = 0;
    for (int i = 0; i < 5; i++) v.push_back(mk(3, 1, 0, 0, 0, 16'h0003, 1, 0, 0));
    v.push_back(mk(3, 0, 0, 0, 0, 16'h0003, 1, 0, 0));
    v.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
    v.push_back(mk(1, 1, 0, 0, 0, 16'h0001, 1, 0, 0));
    v.push_back(mk(1, 0, 0, 0, 0, 16'h0001, 1, 0, 0));
    v.push_back(mk(2, 1, 0, 0, 0, 16'h0012, 2, 0, 0));
    v.push_back(mk(2, 0, 0, 0, 0, 16'h0012, 2, 0, 0));
    v.push_back(mk(12, 1, 0, 0, 0, 16'h0129, 3, 0, 0));
    v.push_back(mk(12, 0, 0, 0, 0, 16'h0129, 3, 0, 0));
    v.push_back(mk(7, 1, 0, 0, 0, E4, 4, 0, 0));
    v.push_back(mk(7, 0, 0, 0, 0, E4, 4, 0, 0));
    v.push_back(mk(4, 1, 0, 0, 0, E4, 4, 0, 1));
    v.push_back(mk(4, 0, 0, 0, 0, E4, 4, 0, 1));
    v.push_back(mk(0, 0, 0, 1, 0, E4, 4, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
    v.push_back(mk(5, 1, 0, 0, 0, 16'h0005, 1, 0, 0));
    v.push_back(mk(5, 0, 0, 0, 0, 16'h0005, 1, 0, 0));
    v.push_back(mk(6, 1, 1, 0, 0, 16'h0000, 0, 0, 0));
    v.push_back(mk(6, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
    v.push_back(mk(3, 1, 0, 0, 0, 16'h0003, 1, 0, 0));
    v.push_back(mk(3, 0, 0, 0, 0, 16'h0003, 1, 0, 0));
    v.push_back(mk(4, 1, 0, 1, 0, 16'h0003, 1, 1, 0));
    v.push_back(mk(4, 0, 0, 0, 0, 16'h0003, 1, 1, 0));
    v.push_back(mk(8, 1, 0, 0, 0, 16'h0003, 1, 1, 0));
    v.push_back(mk(8, 0, 1, 1, 0, 16'h0003, 1, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
    #12;
    chk("reset", 16'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (v[i]) begin
      drive(v[i].kc, v[i].kv, v[i].clr, v[i].cm, v[i].lr);
      chk($sformatf("vec%0d", i), v[i].d, v[i].c, v[i].lv, v[i].o);
    end
    press(1);
    press(2);
    drive(0, 0, 0, 1, 0);
    chk("stall_commit", 16'h0012, 2, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("stall_hold", 16'h0012, 2, 1, 0);
    end
    drive(0, 0, 0, 0, 1);
    chk("stall_accept", 16'h0, 0, 0, 0);
    press(1);
    press(2);
    drive(0, 0, 0, 1, 0);
    chk("rst_offer", 16'h0012, 2, 1, 0);
    #2;
    rst_n = 1'b0;
    bus.commit = 0;
    #1;
    chk("rst_async", 16'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1);
      chk("rst_no_lv", 16'h0, 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    bus.key_code = 4;
    bus.key_valid = 1;
    bus.load_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("held_key_after_rst", 16'h0004, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(4, 1, 0, 0, 0);
    chk("held_key_once", 16'h0004, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    press(9);
    press(0);
    chk("mmss", E90, 2, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
